// File: rtl/branch_predict_ctrl_if.sv
// Branch predictor / flush controller bundle.
// Groups the fetch-side prediction lookup, the EX-side resolve inputs, the
// redirect/flush outputs, the statistics counters and a debug view of the
// controller FSM state.
//   master : pipeline side (drives if_pc and ex_*, observes the rest)
//   slave  : branch_predict_ctrl (drives prediction, redirect, flush, stats)
//
// Handshake semantics: there is no backpressure. An EX branch is consumed in
// the cycle it is presented when ex_valid & ex_branch are high and the
// controller is not busy; while busy the ex_* inputs are wrong-path and are
// dropped without effect. redirect_valid is a single-cycle strobe that
// qualifies redirect_pc in the same cycle.
interface branch_predict_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] if_pc;
  logic                  if_pred_taken;
  logic                  ex_valid;
  logic                  ex_branch;
  logic                  ex_taken;
  logic                  ex_pred_taken;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [DATA_WIDTH-1:0] ex_target;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  flush;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  branch_cnt;
  logic [CNT_WIDTH-1:0]  mispredict_cnt;
  logic                  dbg_state;   // 0 = IDLE, 1 = FLUSH

  modport master (
    output if_pc, ex_valid, ex_branch, ex_taken, ex_pred_taken, ex_pc, ex_target,
    input  if_pred_taken, redirect_valid, redirect_pc, flush, busy,
           branch_cnt, mispredict_cnt, dbg_state
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_taken, ex_pred_taken, ex_pc, ex_target,
    output if_pred_taken, redirect_valid, redirect_pc, flush, busy,
           branch_cnt, mispredict_cnt, dbg_state
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and flush controller for the pipelined RV32I core.
// A table of 2-bit saturating counters is read combinationally at fetch and
// trained when a conditional branch resolves in EX. A mispredict redirects the
// PC in the same cycle and holds flush for FLUSH_CYCLES consecutive cycles,
// during which EX contents are wrong-path and ignored. Saturating statistics
// count resolved and mispredicted branches.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bp   - branch_predict_ctrl_if slave modport (prediction, resolve,
//          redirect, flush/busy, statistics, debug state)
module branch_predict_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_ctrl_if.slave   bp
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [FC_W-1:0]      fcnt_q, fcnt_d;
  logic [1:0]           bht_q [BHT_ENTRIES];
  logic [1:0]           bht_d [BHT_ENTRIES];
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  logic [IDX_W-1:0]     if_idx;
  logic [IDX_W-1:0]     ex_idx;
  logic                 resolve;
  logic                 mispredict;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign ex_idx = bp.ex_pc[IDX_W+1:2];

  // Prediction is the counter MSB, read before any same-cycle update.
  assign bp.if_pred_taken = bht_q[if_idx][1];

  // Gated with rst so the Mealy outputs stay low while reset is asserted.
  assign resolve    = !rst && bp.ex_valid && bp.ex_branch && (state_q == ST_IDLE);
  assign mispredict = resolve && (bp.ex_taken != bp.ex_pred_taken);

  assign bp.redirect_valid = mispredict;
  assign bp.redirect_pc    = bp.ex_taken ? bp.ex_target
                                         : bp.ex_pc + DATA_WIDTH'(4);
  assign bp.flush          = mispredict || (state_q == ST_FLUSH);
  assign bp.busy           = (state_q == ST_FLUSH);
  assign bp.branch_cnt     = bcnt_q;
  assign bp.mispredict_cnt = mcnt_q;
  assign bp.dbg_state      = state_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    bht_d   = bht_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;

    case (state_q)
      ST_IDLE: begin
        // With FLUSH_CYCLES == 1 the M cycle alone covers the flush.
        if (mispredict && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q - FC_W'(1);
        if (fcnt_q == FC_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase

    if (resolve) begin
      if (bp.ex_taken) begin
        if (bht_q[ex_idx] != 2'b11) begin
          bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
        end
      end else begin
        if (bht_q[ex_idx] != 2'b00) begin
          bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
        end
      end
      if (bcnt_q != '1) begin
        bcnt_d = bcnt_q + CNT_WIDTH'(1);
      end
    end

    if (mispredict && (mcnt_q != '1)) begin
      mcnt_d = mcnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
      bht_q   <= bht_d;
    end
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and flush controller for the pipelined RV32I core. It predicts taken/not-taken at fetch from a table of 2-bit saturating counters, and resolves the prediction in EX against the branch comparator's taken output. On a mispredict it issues the PC redirect and sequences a multi-cycle front-end flush. It also keeps saturating branch and mispredict statistics counters.

## Interface
- DATA_WIDTH, 32, PC and target width
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2; index = pc[$clog2(BHT_ENTRIES)+1:2]
- FLUSH_CYCLES, 2, cycles flush is held per mispredict (≥1)
- CNT_WIDTH, 32, width of statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_pc  in  DATA_WIDTH  fetch PC
- if_pred_taken  out  1  prediction for if_pc (combinational BHT read, MSB of counter)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_taken  in  1  comparator decision for EX branch
- ex_pred_taken  in  1  prediction carried down the pipe with the branch
- ex_pc  in  DATA_WIDTH  PC of EX instruction
- ex_target  in  DATA_WIDTH  computed branch target
- redirect_valid  out  1  load redirect_pc into PC this cycle
- redirect_pc  out  DATA_WIDTH  corrected fetch address
- flush  out  1  squash IF/ID stage contents
- busy  out  1  FSM in FLUSH state
- branch_cnt  out  CNT_WIDTH  resolved branches
- mispredict_cnt  out  CNT_WIDTH  mispredicted branches

## Operation
- Resolve event R = ex_valid & ex_branch & (state==IDLE). Mispredict M = R & (ex_taken != ex_pred_taken).
- BHT: counters 00 SNT, 01 WNT, 10 WT, 11 ST. On R, counter at ex_pc index increments if ex_taken, else decrements; saturates at 11/00.
- Prediction read is combinational; no bypass. A read and an update to the same index in one cycle returns the pre-update value.
- redirect_pc = ex_taken ? ex_target : ex_pc + 4, modulo 2^DATA_WIDTH (wraps, no carry out).
- redirect_valid = M (Mealy, same cycle). Its value is irrelevant when redirect_valid=0; it is driven per formula regardless.
- FSM states:
  - IDLE: flush = M. On M with FLUSH_CYCLES>1, go to FLUSH with flush counter = FLUSH_CYCLES-1. On M with FLUSH_CYCLES=1, stay IDLE.
  - FLUSH: flush=1, busy=1, all ex_* inputs ignored (wrong path). There is no BHT update, no counting, and no redirect. The counter decrements each cycle; return to IDLE when it reaches 1→0 transition, i.e. after FLUSH_CYCLES-1 cycles in FLUSH.
- Statistics: branch_cnt +1 on R; mispredict_cnt +1 on M. Both saturate at all-ones and never wrap.
- Non-branch or invalid EX instructions have no effect.

## Timing
- Reset (async assert, released synchronously by the system): all BHT entries = 01, state IDLE, flush counter 0, branch_cnt = mispredict_cnt = 0.
- Outputs during reset: redirect_valid=0, flush=0, busy=0, if_pred_taken=0.
- Reset mid-FLUSH aborts the flush immediately. flush deasserts asynchronously with rst.
- BHT update and counter increments land at the rising edge ending the R cycle and are visible the next cycle.
- Total flush assertion per mispredict is exactly FLUSH_CYCLES consecutive cycles, starting in the M cycle.
- Back-to-back branches in EX during FLUSH are discarded. A branch in EX on the first IDLE cycle after FLUSH resolves normally.
- Latency if_pc→if_pred_taken: 0 cycles. Resolve→redirect: 0 cycles.

## Test plan
- Reset: after rst, if_pred_taken=0 for every index, counters 0, flush=0. Assert rst mid-FLUSH → flush=0 and busy=0 immediately.
- Training: 3 resolves at ex_pc=0x40, all taken, ex_pred_taken=0/1/1 → BHT[0] goes 01→10→11→11. Prediction at if_pc=0x40 turns 1 after the first update. Counts: branch_cnt=3, mispredict_cnt=1.
- Mispredict taken: ex_pc=0x100, ex_target=0x80, ex_taken=1, ex_pred_taken=0 → same cycle redirect_valid=1, redirect_pc=0x80, flush=1. flush stays high 2 cycles total (FLUSH_CYCLES=2), busy=1 in the second cycle.
- Mispredict not-taken with wrap: ex_pc=0xFFFFFFFC, ex_taken=0, ex_pred_taken=1 → redirect_pc=0x00000000.
- Wrong-path suppression: mispredict, then a mispredicting branch presented in the FLUSH cycle → no redirect, no BHT change, counters unchanged. The same branch presented one cycle later is resolved.
- Saturation: CNT_WIDTH=4, 20 mispredicts → branch_cnt = mispredict_cnt = 15. Index aliasing: ex_pc=0x04 and 0x44 (BHT_ENTRIES=16) update the same counter.
